// File: rtl/uart_rx.sv
// uart_rx -- 8N1 asynchronous serial receiver.
//   Oversamples the line by CLKS_PER_BIT and samples every bit at its centre.
//   Ports:
//     i_clk          system clock, rising edge
//     i_rst          asynchronous reset, active low
//     i_rx           serial line, asynchronous to i_clk, idles high
//     o_data[7:0]    last correctly framed byte, held until the next good frame
//     o_valid        one-cycle pulse when o_data has been updated
//     o_framing_err  one-cycle pulse when the stop bit is sampled low
//     o_busy         high whenever the receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_framing_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  state_t        r_state, w_next;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid, r_ferr;

  logic w_rx_s, w_half, w_full;
  logic w_cnt_clr, w_cnt_inc, w_idx_clr, w_idx_inc;
  logic w_shift_en, w_load, w_ferr_set, w_busy;

  // Both synchronizer stages reset high so leaving reset never fakes a start bit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;
  assign w_half = (r_cnt == HALF_M1);
  assign w_full = (r_cnt == FULL_M1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_rx_s) w_next = S_START;
      // Line back high at mid-start means a glitch: drop it without flags.
      S_START: if (w_half) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_full && (r_idx == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_full) w_next = w_rx_s ? S_IDLE : S_BREAK;
      // Wait out a held-low line so it cannot be decoded as repeated frames.
      S_BREAK: if (w_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_idx_clr  = 1'b0;
    w_idx_inc  = 1'b0;
    w_shift_en = 1'b0;
    w_load     = 1'b0;
    w_ferr_set = 1'b0;
    w_busy     = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE:  w_cnt_clr = 1'b1;   // START always begins counting from 0
      S_START: begin
        if (w_half) begin
          w_cnt_clr = 1'b1;
          w_idx_clr = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_shift_en = 1'b1;
          w_cnt_clr  = 1'b1;
          w_idx_inc  = (r_idx != 3'd7);
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STOP: begin
        if (w_full) begin
          w_load     = w_rx_s;
          w_ferr_set = !w_rx_s;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counters, shift register and registered strobes
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;
      // LSB arrives first: shift right so bit 0 ends up holding it.
      if (w_shift_en)     r_shift <= {w_rx_s, r_shift[7:1]};
      if (w_load)         r_data  <= r_shift;
      r_valid <= w_load;
      r_ferr  <= w_ferr_set;
    end
  end

  assign o_data        = r_data;
  assign o_valid       = r_valid;
  assign o_framing_err = r_ferr;
  assign o_busy        = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx16 = 1'b1;
  logic       rx4 = 1'b1;
  logic [7:0] data16, data4;
  logic       valid16, valid4, ferr16, ferr4, busy16, busy4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         v16_cyc[$];
  logic [7:0] v16_dat[$];
  int         f16_cyc[$];
  int         v4_cyc[$];
  logic [7:0] v4_dat[$];
  int         f4_cyc[$];
  int         both_hi = 0;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx16),
    .o_data(data16), .o_valid(valid16), .o_framing_err(ferr16), .o_busy(busy16)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx4),
    .o_data(data4), .o_valid(valid4), .o_framing_err(ferr4), .o_busy(busy4)
  );

  always #5 clk = ~clk;

  // cyc equals k when sampled at the negedge following posedge k
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid16) begin v16_cyc.push_back(cyc); v16_dat.push_back(data16); end
    if (ferr16)  f16_cyc.push_back(cyc);
    if (valid4)  begin v4_cyc.push_back(cyc); v4_dat.push_back(data4); end
    if (ferr4)   f4_cyc.push_back(cyc);
    if ((valid16 && ferr16) || (valid4 && ferr4)) both_hi++;
  end

  task automatic clear_logs();
    v16_cyc.delete(); v16_dat.delete(); f16_cyc.delete();
    v4_cyc.delete();  v4_dat.delete();  f4_cyc.delete();
  endtask

  // Called at a negedge; drives one line level for n clock cycles.
  task automatic drive_bit(input bit sel4, input logic v, input int n);
    if (sel4) rx4 = v; else rx16 = v;
    repeat (n) @(negedge clk);
  endtask

  // e0 is the posedge that first captures the start bit.
  task automatic send_frame(input bit sel4, input int n, input logic [7:0] b,
                            input logic stop, output int e0);
    e0 = cyc + 1;
    drive_bit(sel4, 1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(sel4, b[i], n);
    drive_bit(sel4, stop, n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({data16, valid16, ferr16, busy16} !== 11'h000) begin
      errors++; $display("FAIL reset_n16: got %h required 000", {data16, valid16, ferr16, busy16});
    end
    checks++;
    if ({data4, valid4, ferr4, busy4} !== 11'h000) begin
      errors++; $display("FAIL reset_n4: got %h required 000", {data4, valid4, ferr4, busy4});
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    clear_logs();
  endtask

  task automatic test_single();
    int e0;
    send_frame(1'b0, 16, 8'hA5, 1'b1, e0);
    repeat (20) @(negedge clk);
    checks++;
    if (v16_cyc.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d valid pulses required 1", v16_cyc.size());
    end else begin
      checks++;
      if (v16_cyc[0] != e0 + 154) begin
        errors++; $display("FAIL single_time: got edge E0+%0d required E0+154", v16_cyc[0] - e0);
      end
      checks++;
      if (v16_dat[0] !== 8'hA5) begin
        errors++; $display("FAIL single_data: got %h required a5", v16_dat[0]);
      end
    end
    checks++;
    if (f16_cyc.size() != 0) begin
      errors++; $display("FAIL single_ferr: got %0d pulses required 0", f16_cyc.size());
    end
    checks++;
    if (busy16 !== 1'b0 || data16 !== 8'hA5) begin
      errors++; $display("FAIL single_idle: got busy=%b data=%h required busy=0 data=a5", busy16, data16);
    end
    clear_logs();
  endtask

  task automatic test_back_to_back();
    int e0a, e0b;
    send_frame(1'b0, 16, 8'h00, 1'b1, e0a);
    send_frame(1'b0, 16, 8'hFF, 1'b1, e0b);
    repeat (20) @(negedge clk);
    checks++;
    if (v16_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d valid pulses required 2", v16_cyc.size());
    end else begin
      checks++;
      if (v16_cyc[0] != e0a + 154 || v16_cyc[1] - v16_cyc[0] != 160) begin
        errors++; $display("FAIL b2b_time: got E0+%0d gap %0d required E0+154 gap 160",
                           v16_cyc[0] - e0a, v16_cyc[1] - v16_cyc[0]);
      end
      checks++;
      if (v16_dat[0] !== 8'h00 || v16_dat[1] !== 8'hFF) begin
        errors++; $display("FAIL b2b_data: got %h,%h required 00,ff", v16_dat[0], v16_dat[1]);
      end
    end
    checks++;
    if (f16_cyc.size() != 0) begin
      errors++; $display("FAIL b2b_ferr: got %0d pulses required 0", f16_cyc.size());
    end
    clear_logs();
  endtask

  task automatic test_glitch();
    int busy_cycles = 0;
    rx16 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) rx16 = 1'b1;
      if (busy16) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 8) begin
      errors++; $display("FAIL glitch_busy: got %0d busy cycles required 8", busy_cycles);
    end
    checks++;
    if (v16_cyc.size() != 0 || f16_cyc.size() != 0 || busy16 !== 1'b0) begin
      errors++; $display("FAIL glitch_flags: got valid=%0d ferr=%0d busy=%b required 0 0 0",
                         v16_cyc.size(), f16_cyc.size(), busy16);
    end
    clear_logs();
  endtask

  task automatic test_framing();
    int e0a, e0b;
    logic b261, b262;
    send_frame(1'b0, 16, 8'h5A, 1'b1, e0a);
    repeat (10) @(negedge clk);
    send_frame(1'b0, 16, 8'h3C, 1'b0, e0b);
    drive_bit(1'b0, 1'b0, 100);          // cyc is now E0+259
    rx16 = 1'b1;
    @(negedge clk);
    @(negedge clk); b261 = busy16;
    @(negedge clk); b262 = busy16;
    repeat (40) @(negedge clk);
    checks++;
    if (f16_cyc.size() != 1) begin
      errors++; $display("FAIL ferr_count: got %0d pulses required 1", f16_cyc.size());
    end else begin
      checks++;
      if (f16_cyc[0] != e0b + 154) begin
        errors++; $display("FAIL ferr_time: got E0+%0d required E0+154", f16_cyc[0] - e0b);
      end
    end
    checks++;
    if (v16_cyc.size() != 1 || data16 !== 8'h5A) begin
      errors++; $display("FAIL ferr_data: got %0d valids data=%h required 1 valid data=5a",
                         v16_cyc.size(), data16);
    end
    checks++;
    if (b261 !== 1'b1 || b262 !== 1'b0) begin
      errors++; $display("FAIL ferr_break_busy: got %b%b required 10", b261, b262);
    end
    clear_logs();
  endtask

  task automatic test_reset_mid();
    int e0;
    rx16 = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'(i % 2), 16);
    drive_bit(1'b0, 1'b1, 8);            // middle of data bit 4
    checks++;
    if (busy16 !== 1'b1 || data16 !== 8'h5A) begin
      errors++; $display("FAIL rstmid_pre: got busy=%b data=%h required 1 5a", busy16, data16);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({data16, valid16, ferr16, busy16} !== 11'h000) begin
      errors++; $display("FAIL rstmid_async: got %h required 000", {data16, valid16, ferr16, busy16});
    end
    rx16 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    clear_logs();
    send_frame(1'b0, 16, 8'h81, 1'b1, e0);
    repeat (20) @(negedge clk);
    checks++;
    if (v16_cyc.size() != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d valid pulses required 1", v16_cyc.size());
    end else begin
      checks++;
      if (v16_dat[0] !== 8'h81 || v16_cyc[0] != e0 + 154) begin
        errors++; $display("FAIL rstmid_frame: got %h at E0+%0d required 81 at E0+154",
                           v16_dat[0], v16_cyc[0] - e0);
      end
    end
    clear_logs();
  endtask

  task automatic test_n4();
    int e0;
    send_frame(1'b1, 4, 8'h96, 1'b1, e0);
    repeat (10) @(negedge clk);
    checks++;
    if (v4_cyc.size() != 1) begin
      errors++; $display("FAIL n4_count: got %0d valid pulses required 1", v4_cyc.size());
    end else begin
      checks++;
      if (v4_cyc[0] != e0 + 40) begin
        errors++; $display("FAIL n4_time: got E0+%0d required E0+40", v4_cyc[0] - e0);
      end
      checks++;
      if (v4_dat[0] !== 8'h96) begin
        errors++; $display("FAIL n4_data: got %h required 96", v4_dat[0]);
      end
    end
    checks++;
    if (f4_cyc.size() != 0) begin
      errors++; $display("FAIL n4_ferr: got %0d pulses required 0", f4_cyc.size());
    end
    clear_logs();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_n4();
    checks++;
    if (both_hi != 0) begin
      errors++; $display("FAIL strobe_overlap: got %0d cycles required 0", both_hi);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver. It recovers 8N1 frames from a single `rx` line and presents each byte on a parallel output with a one-cycle valid strobe. The frame format is idle-high, one low start bit, 8 data bits LSB first, and one high stop bit. It is the receive-side counterpart to the UART transmitter in the same serial link and sits between the pad and the byte consumer. It oversamples by a fixed integer ratio and samples each bit at its centre.

## Interface
- `CLKS_PER_BIT`, default 16, is the number of `clk` cycles per serial bit. It must be even and at least 4.

- `clk`, input, 1 bit: the system clock. All logic is on its rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset.
- `rx`, input, 1 bit: the serial line. It is asynchronous to `clk` and idles high.
- `data`, output, 8 bits: the last correctly framed byte. It holds until the next good frame.
- `valid`, output, 1 bit: a one-cycle pulse when `data` has been updated.
- `framing_err`, output, 1 bit: a one-cycle pulse when the stop bit is sampled low.
- `busy`, output, 1 bit: high in every state except IDLE.

## Operation
- Synchronizer: two flops on `rx`. Both reset to 1 so reset never looks like a start bit. The FSM uses only the second-stage output, called `rx_s`.
- Counters:
  - `cnt`: bit-period counter, width ceil(log2(CLKS_PER_BIT)).
  - `idx`: bit index, 0–7.
  - Shift register: 8 bits. Each sample is shifted in at bit 7 and the register shifts right, so the first bit received lands in bit 0.
- State transitions:
  - IDLE: when `rx_s`==0, clear `cnt` and go to START.
  - START: when `cnt`==CLKS_PER_BIT/2−1, sample `rx_s`.
    - If it is 0, clear `cnt` and `idx` and go to DATA.
    - If it is 1, the start was a glitch: go to IDLE silently with no flags.
    - Otherwise increment `cnt`.
  - DATA: when `cnt`==CLKS_PER_BIT−1, shift in `rx_s` and clear `cnt`.
    - If `idx`==7, go to STOP; otherwise increment `idx`.
    - Otherwise increment `cnt`.
  - STOP: when `cnt`==CLKS_PER_BIT−1, sample `rx_s`.
    - If it is 1, load `data` from the shift register, pulse `valid`, and go to IDLE.
    - If it is 0, pulse `framing_err`, leave `data` unchanged, and go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- `valid` and `framing_err` are registered, never high together, and never high for more than one cycle.
- After `valid`, IDLE can detect a new start on the next edge. A back-to-back frame whose start follows the stop bit directly is received without loss.
- `rst` asserted at any point forces all state immediately to these values:
  - FSM to IDLE.
  - `cnt`, `idx`, shift register and `data` to 0.
  - `valid`, `framing_err` and `busy` to 0.
  - Synchronizer flops to 1.
- After reset is released, a frame already in progress on the line is not recovered. The next falling edge is treated as a start.

## Timing
- Reset values: `data`=0x00, `valid`=0, `framing_err`=0, `busy`=0.
- Let E0 be the first `clk` edge at which `rx`=0 is captured, and N = CLKS_PER_BIT.
  - `rx_s` falls after E1.
  - START is entered at E2.
  - `busy` is high from after E2.
- Sampling points:
  - Start bit confirmed at edge E2+N/2.
  - Data bit i (0–7) sampled at edge E2+N/2+(i+1)·N.
  - Stop bit sampled at edge E2+N/2+9N.
- Each sample point corresponds to the pin value at mid-bit.
- `valid` or `framing_err` is high for exactly the cycle after edge E0+2+N/2+9N. For N=16 that is edge E0+154. `busy` falls at the same edge on a good frame.
- Tolerated baud mismatch is at least ±4% at N=16.

## Test plan
- N=16; send 0xA5 (line low E0..E0+15, then bits 1,0,1,0,0,1,0,1, then stop high) → `valid`=1 only in the cycle after E0+154, `data`=0xA5, `framing_err` stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap between frames → two `valid` pulses 160 cycles apart, `data` 0x00 then 0xFF, no framing error.
- `rx` low for 3 cycles then high → no `valid`, no `framing_err`; `busy` high for 8 cycles, then returns to 0 (idle).
- 0x3C sent after a good 0x5A, with the stop bit driven low and `rx` held low for 100 further cycles → one `framing_err` pulse; `data` stays 0x5A; `busy` stays 1 until 2 cycles after `rx` returns high; no second frame is decoded.
- `rst` pulled low during data bit 4 of a frame → all outputs 0 immediately. After release with `rx` idle, a following frame of 0x81 is received correctly.
- N=4; send 0x96 → `valid` in the cycle after E0+40, `data`=0x96.
